// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolution controller: stalls while beq operands are still in
// flight in EX/MEM, then drives PC-select/flush and keeps resolution statistics.
module branch_resolve_ctrl #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              branch_i,
    input  logic              cmp_eq_i,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    input  logic [ADDR_W-1:0] ex_rd_i,
    input  logic              ex_regwrite_i,
    input  logic              ex_memread_i,
    input  logic [ADDR_W-1:0] mem_rd_i,
    input  logic              mem_memread_i,
    input  logic              stall_ext_i,
    output logic              stall_o,
    output logic              pc_sel_o,
    output logic              flush_o,
    output logic [CNT_W-1:0]  branch_cnt_o,
    output logic [CNT_W-1:0]  taken_cnt_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_cnt;
    logic [1:0]        w_cnt_nxt;
    logic [CNT_W-1:0]  r_branch_cnt;
    logic [CNT_W-1:0]  r_taken_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_ex_match;
    logic              w_mem_match;
    logic [1:0]        w_need;
    logic              w_stall;
    logic              w_pc_sel;
    logic              w_flush;
    logic              w_branch_inc;
    logic              w_taken_inc;
    logic              w_stall_inc;

    // x0 is hard-wired, so a zero rd never creates a dependency
    assign w_ex_match  = (ex_rd_i != '0) &&
                         ((rs1_addr_i == ex_rd_i) || (rs2_addr_i == ex_rd_i));
    assign w_mem_match = (mem_rd_i != '0) &&
                         ((rs1_addr_i == mem_rd_i) || (rs2_addr_i == mem_rd_i));

    always_comb begin
        w_need = 2'd0;
        if (ex_memread_i && w_ex_match)
            w_need = 2'd2;
        else if (ex_regwrite_i && w_ex_match)
            w_need = 2'd1;
        else if (mem_memread_i && w_mem_match)
            w_need = 2'd1;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_stall      = 1'b0;
        w_pc_sel     = 1'b0;
        w_flush      = 1'b0;
        w_branch_inc = 1'b0;
        w_taken_inc  = 1'b0;
        w_stall_inc  = 1'b0;
        case (r_state)
            S_RUN: begin
                if (branch_i && !stall_ext_i) begin
                    case (w_need)
                        2'd0: begin
                            w_pc_sel     = cmp_eq_i;
                            w_flush      = cmp_eq_i;
                            w_branch_inc = 1'b1;
                            w_taken_inc  = cmp_eq_i;
                        end
                        2'd1: begin
                            w_stall     = 1'b1;
                            w_stall_inc = 1'b1;
                        end
                        default: begin
                            w_stall     = 1'b1;
                            w_stall_inc = 1'b1;
                            w_cnt_nxt   = 2'd1;
                            w_state_nxt = S_WAIT;
                        end
                    endcase
                end
            end
            S_WAIT: begin
                w_stall     = 1'b1;
                w_stall_inc = 1'b1;
                w_cnt_nxt   = r_cnt - 2'd1;
                // <= 1 rather than == 1 so a corrupted zero count cannot lock up
                if (r_cnt <= 2'd1) begin
                    w_cnt_nxt   = 2'd0;
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
                w_cnt_nxt   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_RUN;
            r_cnt        <= 2'd0;
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
            r_stall_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_branch_inc) r_branch_cnt <= r_branch_cnt + 1'b1;
            if (w_taken_inc)  r_taken_cnt  <= r_taken_cnt + 1'b1;
            if (w_stall_inc)  r_stall_cnt  <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_o      = w_stall  && !rst_i;
    assign pc_sel_o     = w_pc_sel && !rst_i;
    assign flush_o      = w_flush  && !rst_i;
    assign branch_cnt_o = r_branch_cnt;
    assign taken_cnt_o  = r_taken_cnt;
    assign stall_cnt_o  = r_stall_cnt;

endmodule
